// File: rtl/fifo_shift_arb_pkg.sv
// Shared types and helpers for the fifo_shift write-side arbiter.
//   arb_state_t : arbiter FSM states (IDLE, GRANT)
//   STAT_W      : width of each per-requester transfer statistics counter
//   rr_next()   : round-robin successor index, wrapping n-1 -> 0
package fifo_shift_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  localparam int unsigned STAT_W = 32'd32;

  // Index that gets top priority after requester idx finishes its burst.
  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    if (idx + 32'd1 >= n) begin
      return 32'd0;
    end else begin
      return idx + 32'd1;
    end
  endfunction

endpackage

// File: rtl/fifo_shift_wr_arb_rr_pick.sv
// Combinational round-robin picker.
// Searches req starting at ptr, then ptr+1, ... wrapping at N-1 -> 0, and
// reports the first asserted requester.
//   req    in  N   request vector
//   ptr    in  IW  highest-priority index (must be < N)
//   onehot out N   one-hot of the chosen requester (0 when none)
//   idx    out IW  index of the chosen requester (0 when none)
//   any    out 1   at least one request asserted
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] idx,
  output logic          any
);

  // Rotating priority scan; the first hit latches via 'any'.
  always_comb begin
    int unsigned j;
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    j      = 32'd0;
    for (int k = 0; k < N; k++) begin
      j = 32'(ptr) + 32'(k);
      if (j >= 32'(N)) begin
        j = j - 32'(N);
      end else begin
        j = j;
      end
      if (!any && req[j]) begin
        any       = 1'b1;
        onehot[j] = 1'b1;
        idx       = IW'(j);
      end else begin
        any = any;
      end
    end
  end

endmodule

// File: rtl/fifo_shift_wr_arb.sv
// Round-robin write arbiter sharing one fifo_shift_prefetch write port among
// NUM_REQ requesters. One requester is granted at a time and keeps the grant
// for a burst that ends on req_last or after MAX_BURST words.
// Optional feature macro: WR_ARB_STATS_EN (per-requester transfer counters).
// Ports:
//   clk, rst        clock; asynchronous active-low reset
//   req_valid/last  per-requester word valid / last-of-burst
//   req_data        per-requester word, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_ready       per-requester accept
//   fifo_wr_en/data FIFO write side
//   fifo_wr_vld     FIFO can accept a word this cycle
//   grant_id        current / last granted requester
//   busy            high while a grant is held
//   stat_clr/cnt    (WR_ARB_STATS_EN only) sync clear / 32-bit counters per requester
module fifo_shift_wr_arb
  import fifo_shift_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_last,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         fifo_wr_data,
  input  logic                          fifo_wr_vld,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic                          busy
`ifdef WR_ARB_STATS_EN
  ,
  input  logic                          stat_clr,
  output logic [NUM_REQ*STAT_W-1:0]     stat_cnt
`endif
);

  localparam int IW     = $clog2(NUM_REQ);
  localparam int BCNT_W = $clog2(MAX_BURST + 1);

  arb_state_t           state_r, state_n_s;
  logic [IW-1:0]        grant_r, grant_n_s;
  logic [NUM_REQ-1:0]   grant_oh_r, grant_oh_n_s;
  logic [IW-1:0]        rr_ptr_r, rr_ptr_n_s;
  logic [BCNT_W-1:0]    bcnt_r, bcnt_n_s;
  logic [NUM_REQ-1:0]   pick_oh_s;
  logic [IW-1:0]        pick_idx_s;
  logic                 pick_any_s;
  logic                 transfer_s;

  rr_pick #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_pick (
    .req    (req_valid),
    .ptr    (rr_ptr_r),
    .onehot (pick_oh_s),
    .idx    (pick_idx_s),
    .any    (pick_any_s)
  );

  // FSM state, grant, round-robin pointer and burst counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= IDLE;
      grant_r    <= '0;
      grant_oh_r <= '0;
      rr_ptr_r   <= '0;
      bcnt_r     <= '0;
    end else begin
      state_r    <= state_n_s;
      grant_r    <= grant_n_s;
      grant_oh_r <= grant_oh_n_s;
      rr_ptr_r   <= rr_ptr_n_s;
      bcnt_r     <= bcnt_n_s;
    end
  end

  // Next-state logic and write-port muxing; outputs are quiet in IDLE.
  always_comb begin
    state_n_s    = state_r;
    grant_n_s    = grant_r;
    grant_oh_n_s = grant_oh_r;
    rr_ptr_n_s   = rr_ptr_r;
    bcnt_n_s     = bcnt_r;
    req_ready    = '0;
    fifo_wr_en   = 1'b0;
    fifo_wr_data = '0;
    transfer_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (pick_any_s) begin
          grant_n_s    = pick_idx_s;
          grant_oh_n_s = pick_oh_s;
          bcnt_n_s     = '0;
          state_n_s    = GRANT;
        end else begin
          state_n_s = IDLE;
        end
      end
      GRANT: begin
        fifo_wr_en   = req_valid[grant_r];
        fifo_wr_data = req_data[grant_r*DATA_WIDTH +: DATA_WIDTH];
        req_ready    = grant_oh_r & {NUM_REQ{fifo_wr_vld}};
        transfer_s   = req_valid[grant_r] & fifo_wr_vld;
        if (transfer_s) begin
          // bcnt counts words already moved, so this word is number bcnt+1.
          if (req_last[grant_r] || ((bcnt_r + BCNT_W'(1)) == BCNT_W'(MAX_BURST))) begin
            state_n_s  = IDLE;
            bcnt_n_s   = '0;
            rr_ptr_n_s = IW'(rr_next(32'(grant_r), 32'(NUM_REQ)));
          end else begin
            bcnt_n_s = bcnt_r + BCNT_W'(1);
          end
        end else begin
          bcnt_n_s = bcnt_r;
        end
      end
      default: begin
        state_n_s = IDLE;
      end
    endcase
  end

  assign busy     = (state_r == GRANT);
  assign grant_id = grant_r;

`ifdef WR_ARB_STATS_EN
  logic [STAT_W-1:0] stat_r [NUM_REQ];

  // Saturating per-requester transfer counters; clear beats increment.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        stat_r[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (stat_clr) begin
          stat_r[i] <= '0;
        end else if (transfer_s && grant_oh_r[i] && (stat_r[i] != {STAT_W{1'b1}})) begin
          stat_r[i] <= stat_r[i] + STAT_W'(1);
        end else begin
          stat_r[i] <= stat_r[i];
        end
      end
    end
  end

  // Flatten counters onto the output bus.
  always_comb begin
    stat_cnt = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      stat_cnt[i*STAT_W +: STAT_W] = stat_r[i];
    end
  end
`endif

endmodule

// File: tb/tb_fifo_shift_wr_arb.sv
// Self-checking bench for fifo_shift_wr_arb (NUM_REQ=4, DATA_WIDTH=8, MAX_BURST=16).
// Per-requester expected-word queues are filled when stimulus is loaded and
// drained as the FIFO write port moves words; an expected-burst queue holds
// (requester, length) pairs compared when each grant ends.
// Build with WR_ARB_STATS_EN defined to also exercise the statistics counters.
module tb_fifo_shift_wr_arb;

  localparam int NR = 4;
  localparam int DW = 8;
  localparam int MB = 16;

  logic           clk;
  logic           rst;
  logic [NR-1:0]  req_valid;
  logic [NR-1:0]  req_last;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]  req_ready;
  logic           fifo_wr_en;
  logic [DW-1:0]  fifo_wr_data;
  logic           fifo_wr_vld;
  logic [1:0]     grant_id;
  logic           busy;
`ifdef WR_ARB_STATS_EN
  logic           stat_clr;
  logic [NR*32-1:0] stat_cnt;
`endif

  fifo_shift_wr_arb #(
    .NUM_REQ    (NR),
    .DATA_WIDTH (DW),
    .MAX_BURST  (MB)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_last     (req_last),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .fifo_wr_en   (fifo_wr_en),
    .fifo_wr_data (fifo_wr_data),
    .fifo_wr_vld  (fifo_wr_vld),
    .grant_id     (grant_id),
    .busy         (busy)
`ifdef WR_ARB_STATS_EN
    ,
    .stat_clr     (stat_clr),
    .stat_cnt     (stat_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Count one comparison; report it if it does not match.
  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Stimulus store and scoreboards.
  logic [7:0] src_dat [NR][64];
  logic       src_lst [NR][64];
  int         src_len [NR];
  int         src_pos [NR];
  logic [7:0] exp_q0[$];
  logic [7:0] exp_q1[$];
  logic [7:0] exp_q2[$];
  logic [7:0] exp_q3[$];
  logic [15:0] gexp_q[$];
  bit         drv_en;
  bit         chk_gap;
  bit         gap_first;
  int         burst_len;
  int         idle_run;
  logic       busy_prev;

  task automatic push_exp(input int id, input logic [7:0] d);
    case (id)
      0: exp_q0.push_back(d);
      1: exp_q1.push_back(d);
      2: exp_q2.push_back(d);
      default: exp_q3.push_back(d);
    endcase
  endtask

  task automatic pop_exp(input int id, output logic [7:0] d, output bit ok);
    ok = 1'b0;
    d  = 8'h00;
    case (id)
      0: if (exp_q0.size() > 0) begin d = exp_q0.pop_front(); ok = 1'b1; end
      1: if (exp_q1.size() > 0) begin d = exp_q1.pop_front(); ok = 1'b1; end
      2: if (exp_q2.size() > 0) begin d = exp_q2.pop_front(); ok = 1'b1; end
      default: if (exp_q3.size() > 0) begin d = exp_q3.pop_front(); ok = 1'b1; end
    endcase
  endtask

  // mode 0: no last, 1: last on final word, 2: every word last.
  task automatic load_req(input int id, input int n, input int mode);
    for (int k = 0; k < n; k++) begin
      logic [7:0] d;
      d = 8'((id + 1) * 16 + src_len[id]);
      src_dat[id][src_len[id]] = d;
      src_lst[id][src_len[id]] = (mode == 2) || ((mode == 1) && (k == n - 1));
      push_exp(id, d);
      src_len[id]++;
    end
  endtask

  task automatic exp_burst(input int id, input int len);
    gexp_q.push_back({8'(id), 8'(len)});
  endtask

  function automatic bit all_done();
    bit r;
    r = !busy && (gexp_q.size() == 0) && (exp_q0.size() == 0) && (exp_q1.size() == 0)
        && (exp_q2.size() == 0) && (exp_q3.size() == 0);
    for (int i = 0; i < NR; i++) begin
      if (src_pos[i] != src_len[i]) r = 1'b0;
    end
    return r;
  endfunction

  task automatic wait_done(input string tag, input int budget);
    int c;
    c = 0;
    @(negedge clk);
    while (!all_done() && c < budget) begin
      @(negedge clk);
      c++;
    end
    if (c >= budget) check_val({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic sync_drive();
    @(posedge clk);
    #2;
  endtask

  // Requester models: present the head word, advance after an accept.
  initial begin
    logic [NR-1:0] fired;
    forever begin
      @(negedge clk);
      fired = req_valid & req_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < NR; i++) begin
        if (fired[i]) src_pos[i]++;
      end
      if (drv_en) begin
        for (int i = 0; i < NR; i++) begin
          int p;
          p = (src_pos[i] < 64) ? src_pos[i] : 63;
          req_valid[i]          = (src_pos[i] < src_len[i]);
          req_data[i*DW +: DW]  = src_dat[i][p];
          req_last[i]           = src_lst[i][p];
        end
      end
    end
  end

  // Output monitor: data scoreboard, burst length/owner, idle gap.
  initial begin
    logic [7:0] e;
    bit ok;
    forever begin
      @(negedge clk);
      if (!rst) begin
        busy_prev = 1'b0;
        burst_len = 0;
        idle_run  = 0;
      end else begin
        if (fifo_wr_en && fifo_wr_vld) begin
          pop_exp(int'(grant_id), e, ok);
          if (!ok) begin
            check_val("unexpected_write", 32'd1, 32'd0);
          end else begin
            check_val("wdata", 32'(fifo_wr_data), 32'(e));
          end
          check_val("ready_onehot", 32'(req_ready), 32'd1 << grant_id);
          burst_len++;
        end
        if (!busy) idle_run++;
        if (busy && !busy_prev) begin
          if (chk_gap && !gap_first) check_val("idle_gap", 32'(idle_run), 32'd1);
          gap_first = 1'b0;
          idle_run  = 0;
        end
        if (!busy && busy_prev) begin
          if (gexp_q.size() == 0) begin
            check_val("unexpected_burst", 32'd1, 32'd0);
          end else begin
            logic [15:0] g;
            g = gexp_q.pop_front();
            check_val("burst_owner", 32'(grant_id), 32'(g[15:8]));
            check_val("burst_len", 32'(burst_len), 32'(g[7:0]));
          end
          burst_len = 0;
        end
        busy_prev = busy;
      end
    end
  end

  initial begin
    clk = 1'b0;
    rst = 1'b0;
    req_valid = '0;
    req_last = '0;
    req_data = '0;
    fifo_wr_vld = 1'b1;
    drv_en = 1'b0;
    chk_gap = 1'b0;
    gap_first = 1'b0;
    busy_prev = 1'b0;
    burst_len = 0;
    idle_run = 0;
`ifdef WR_ARB_STATS_EN
    stat_clr = 1'b0;
`endif
    for (int i = 0; i < NR; i++) begin
      src_len[i] = 0;
      src_pos[i] = 0;
    end

    // Reset held with every requester asserting.
    req_valid = 4'hF;
    req_last  = 4'hF;
    req_data  = 32'hA5A5_A5A5;
    repeat (3) @(negedge clk);
    check_val("rst_req_ready", 32'(req_ready), 32'd0);
    check_val("rst_wr_en", 32'(fifo_wr_en), 32'd0);
    check_val("rst_wr_data", 32'(fifo_wr_data), 32'd0);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_grant", 32'(grant_id), 32'd0);
    sync_drive();
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    drv_en    = 1'b1;
    sync_drive();
    rst = 1'b1;
    sync_drive();

    // Single requester 1, three words, one-cycle arbitration latency.
    load_req(1, 3, 1);
    exp_burst(1, 3);
    @(posedge clk);
    @(negedge clk);
    check_val("arb_lat_busy", 32'(busy), 32'd0);
    check_val("arb_lat_wr_en", 32'(fifo_wr_en), 32'd0);
    @(negedge clk);
    check_val("grant_busy", 32'(busy), 32'd1);
    check_val("grant_id_1", 32'(grant_id), 32'd1);
    wait_done("single", 50);

    // rr_ptr now 2: req2 beats req0.
    sync_drive();
    load_req(0, 1, 1);
    load_req(2, 1, 1);
    exp_burst(2, 1);
    exp_burst(0, 1);
    wait_done("rr_ptr", 50);

    // req0 never asserts last: forced rotation after MAX_BURST words.
    sync_drive();
    load_req(0, MB, 0);
    exp_burst(0, MB);
    exp_burst(1, 2);
    @(negedge clk);
    @(negedge clk);
    sync_drive();
    load_req(1, 2, 1);
    wait_done("max_burst", 200);

    // FIFO backpressure for 5 cycles mid-burst on requester 3.
    sync_drive();
    load_req(3, 8, 1);
    exp_burst(3, 8);
    begin
      int c;
      c = 0;
      @(negedge clk);
      #1;
      while (burst_len < 3 && c < 50) begin
        @(negedge clk);
        #1;
        c++;
      end
      if (c >= 50) check_val("stall_setup_timeout", 32'd0, 32'd1);
    end
    sync_drive();
    fifo_wr_vld = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check_val("stall_ready", 32'(req_ready), 32'd0);
      check_val("stall_wr_en", 32'(fifo_wr_en), 32'd1);
      check_val("stall_data", 32'(fifo_wr_data), 32'h43);
      check_val("stall_busy", 32'(busy), 32'd1);
    end
    sync_drive();
    fifo_wr_vld = 1'b1;
    wait_done("stall", 100);

    // Fresh reset, all four continuous 1-word bursts: order 0,1,2,3,0.
    sync_drive();
    rst = 1'b0;
    sync_drive();
    rst = 1'b1;
    chk_gap = 1'b1;
    gap_first = 1'b1;
    load_req(0, 2, 2);
    load_req(1, 1, 2);
    load_req(2, 1, 2);
    load_req(3, 1, 2);
    exp_burst(0, 1);
    exp_burst(1, 1);
    exp_burst(2, 1);
    exp_burst(3, 1);
    exp_burst(0, 1);
    wait_done("all_rr", 100);
    chk_gap = 1'b0;

`ifdef WR_ARB_STATS_EN
    // Statistics: 10 words from req2, then synchronous clear.
    sync_drive();
    rst = 1'b0;
    sync_drive();
    rst = 1'b1;
    load_req(2, 10, 1);
    exp_burst(2, 10);
    wait_done("stats", 100);
    check_val("stat_req0", stat_cnt[0*32 +: 32], 32'd0);
    check_val("stat_req1", stat_cnt[1*32 +: 32], 32'd0);
    check_val("stat_req2", stat_cnt[2*32 +: 32], 32'd10);
    check_val("stat_req3", stat_cnt[3*32 +: 32], 32'd0);
    sync_drive();
    stat_clr = 1'b1;
    sync_drive();
    stat_clr = 1'b0;
    @(negedge clk);
    check_val("stat_clr2", stat_cnt[2*32 +: 32], 32'd0);
    check_val("stat_clr_all", 32'(|stat_cnt), 32'd0);
`endif

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
